// File: rtl/spram_stream_loader_if.sv
// Control, byte-stream and single-port RAM signals of the stream loader.
// master = the loader itself, slave = host/RAM side.
interface spram_stream_loader_if #(
    parameter int ADDR_W = 15
);
    localparam int CNT_W = ADDR_W + 3;

    // transfer control
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  byte_count;
    logic              busy;
    logic              done;

    // LOAD byte stream in
    logic [7:0]        s_dat;
    logic              s_vld;
    logic              s_rdy;

    // DUMP byte stream out
    logic [7:0]        m_dat;
    logic              m_vld;
    logic              m_rdy;

    // single-port RAM bus
    logic              mem_sel;
    logic              mem_wr_en;
    logic [3:0]        mem_wr_mask;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdat;
    logic [31:0]       mem_rdat;

    modport master (
        input  start, mode, base_addr, byte_count,
        input  s_dat, s_vld, m_rdy, mem_rdat,
        output busy, done, s_rdy, m_dat, m_vld,
        output mem_sel, mem_wr_en, mem_wr_mask, mem_addr, mem_wdat
    );

    modport slave (
        output start, mode, base_addr, byte_count,
        output s_dat, s_vld, m_rdy, mem_rdat,
        input  busy, done, s_rdy, m_dat, m_vld,
        input  mem_sel, mem_wr_en, mem_wr_mask, mem_addr, mem_wdat
    );
endinterface

// File: rtl/spram_stream_loader.sv
// Byte stream <-> 32-bit single-port RAM loader (LOAD packs LE words, DUMP unpacks them).
// Latency: one RAM write per 4 bytes plus 1 cycle; DUMP costs 2 cycles of read per word.
// Backpressure: s_rdy only in collect state; m_vld/m_dat held until m_rdy.
module spram_stream_loader #(
    parameter int ADDR_W = 15
) (
    input  logic                  clk,
    input  logic                  reset_i,
    spram_stream_loader_if.master bus
);
    localparam int CNT_W = ADDR_W + 3;

    typedef enum logic [2:0] {
        IDLE, L_COLLECT, L_WRITE, D_READ, D_CAPTURE, D_EMIT, DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        idx_q;
    logic [3:0]        mask_q;
    logic [31:0]       data_q;
    logic [31:0]       rd_q;

    logic              busy_q, done_q, s_rdy_q, m_vld_q;
    logic [7:0]        m_dat_q;
    logic              mem_sel_q, mem_we_q;
    logic [3:0]        mem_mask_q;
    logic [31:0]       mem_wdat_q;

    logic [31:0]       data_nx;
    logic [3:0]        mask_nx;
    logic [1:0]        idx_inc;
    logic              last_byte;

    always_comb begin
        data_nx                      = data_q;
        data_nx[{idx_q, 3'b000} +: 8] = bus.s_dat;
        mask_nx                      = mask_q;
        mask_nx[idx_q]               = 1'b1;
        idx_inc                      = idx_q + 2'd1;
        last_byte                    = (idx_q == 2'd3) || (cnt_q == CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state      <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            mask_q     <= '0;
            data_q     <= '0;
            rd_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            s_rdy_q    <= 1'b0;
            m_vld_q    <= 1'b0;
            m_dat_q    <= '0;
            mem_sel_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_mask_q <= '0;
            mem_wdat_q <= '0;
        end else begin
            // single-cycle strobes default low every cycle
            done_q     <= 1'b0;
            s_rdy_q    <= 1'b0;
            mem_sel_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_mask_q <= '0;
            mem_wdat_q <= '0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr_q <= bus.base_addr;
                        cnt_q  <= bus.byte_count;
                        idx_q  <= '0;
                        busy_q <= 1'b1;
                        if (bus.byte_count == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else if (!bus.mode) begin
                            state   <= L_COLLECT;
                            s_rdy_q <= 1'b1;
                        end else begin
                            state     <= D_READ;
                            mem_sel_q <= 1'b1;
                        end
                    end
                end

                L_COLLECT: begin
                    s_rdy_q <= 1'b1;
                    if (bus.s_vld && s_rdy_q) begin
                        data_q <= data_nx;
                        mask_q <= mask_nx;
                        cnt_q  <= cnt_q - CNT_W'(1);
                        idx_q  <= idx_inc;
                        if (last_byte) begin
                            state      <= L_WRITE;
                            s_rdy_q    <= 1'b0;
                            mem_sel_q  <= 1'b1;
                            mem_we_q   <= 1'b1;
                            mem_mask_q <= mask_nx;
                            mem_wdat_q <= data_nx;
                        end
                    end
                end

                L_WRITE: begin
                    addr_q <= addr_q + ADDR_W'(1);
                    mask_q <= '0;
                    data_q <= '0;
                    idx_q  <= '0;
                    if (cnt_q == '0) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        state   <= L_COLLECT;
                        s_rdy_q <= 1'b1;
                    end
                end

                D_READ: state <= D_CAPTURE;

                // RAM output is only valid this one cycle, so it must be held locally
                D_CAPTURE: begin
                    rd_q    <= bus.mem_rdat;
                    m_dat_q <= bus.mem_rdat[7:0];
                    m_vld_q <= 1'b1;
                    state   <= D_EMIT;
                end

                D_EMIT: begin
                    if (bus.m_rdy) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        idx_q <= idx_inc;
                        if (last_byte) begin
                            addr_q  <= addr_q + ADDR_W'(1);
                            idx_q   <= '0;
                            m_vld_q <= 1'b0;
                            m_dat_q <= '0;
                            if (cnt_q == CNT_W'(1)) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                state     <= D_READ;
                                mem_sel_q <= 1'b1;
                            end
                        end else begin
                            m_dat_q <= rd_q[{idx_inc, 3'b000} +: 8];
                        end
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.s_rdy       = s_rdy_q;
    assign bus.m_vld       = m_vld_q;
    assign bus.m_dat       = m_dat_q;
    assign bus.mem_sel     = mem_sel_q;
    assign bus.mem_wr_en   = mem_we_q;
    assign bus.mem_wr_mask = mem_mask_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdat    = mem_wdat_q;
endmodule

// File: tb/tb_spram_stream_loader.sv
// Directed bench for spram_stream_loader: behavioural RAM, write log, byte-stream driver/sink.
module tb_spram_stream_loader;
    localparam int ADDR_W = 15;
    localparam int CNT_W  = ADDR_W + 3;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
        logic [3:0]        m;
    } wr_t;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    spram_stream_loader_if #(.ADDR_W(ADDR_W)) ifc ();

    spram_stream_loader #(.ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (ifc.master)
    );

    int vecs = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // RAM model; read data is poisoned outside the cycle after a read select
    logic [31:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ifc.mem_sel && ifc.mem_wr_en)
            for (int n = 0; n < 4; n++)
                if (ifc.mem_wr_mask[n]) ram[ifc.mem_addr][8*n +: 8] <= ifc.mem_wdat[8*n +: 8];
        if (ifc.mem_sel && !ifc.mem_wr_en) ifc.mem_rdat <= ram[ifc.mem_addr];
        else                               ifc.mem_rdat <= 32'hDEAD_BEEF;
    end

    wr_t  wq[$];
    int   rd_cycles = 0, sel_cycles = 0, done_pulses = 0, proto_err = 0;
    logic prev_mv = 1'b0, prev_mr = 1'b0;
    logic [7:0] prev_md = '0;

    always @(negedge clk) begin
        if (ifc.mem_sel) sel_cycles++;
        if (ifc.mem_sel && ifc.mem_wr_en) wq.push_back('{ifc.mem_addr, ifc.mem_wdat, ifc.mem_wr_mask});
        if (ifc.mem_sel && !ifc.mem_wr_en) rd_cycles++;
        if (ifc.done) done_pulses++;
        if (ifc.mem_wr_en && !ifc.mem_sel) proto_err++;
        if (!ifc.mem_wr_en && (ifc.mem_wdat != 0 || ifc.mem_wr_mask != 0)) proto_err++;
        if (ifc.done && !ifc.busy) proto_err++;
        if (prev_mv && !prev_mr && (!ifc.m_vld || ifc.m_dat != prev_md)) proto_err++;
        prev_mv = ifc.m_vld;
        prev_mr = ifc.m_rdy;
        prev_md = ifc.m_dat;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic mode, input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt);
        ifc.start      = 1'b1;
        ifc.mode       = mode;
        ifc.base_addr  = base;
        ifc.byte_count = cnt;
        step();
        ifc.start      = 1'b0;
    endtask

    task automatic feed(input bq_t bytes, input int use_gaps);
        foreach (bytes[i]) begin
            logic acc;
            int   n;
            if (use_gaps != 0) repeat (i % 4) step();
            ifc.s_vld = 1'b1;
            ifc.s_dat = bytes[i];
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 50) begin
                acc = ifc.s_rdy;
                step();
                n++;
            end
            chk("s_accept", acc, 1'b1);
            ifc.s_vld = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!ifc.done && n < 200) begin
            step();
            n++;
        end
        chk("done_seen", ifc.done, 1'b1);
        step();
    endtask

    task automatic drain(output bq_t got);
        got = {};
        for (int k = 0; k < 200; k++) begin
            ifc.m_rdy = k[0];
            if (ifc.m_vld && ifc.m_rdy) got.push_back(ifc.m_dat);
            step();
            if (ifc.done) break;
        end
        ifc.m_rdy = 1'b0;
        chk("dump_done", ifc.done, 1'b1);
        step();
    endtask

    task automatic chk_wr(input int i, input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] m);
        if (i < wq.size()) begin
            chk($sformatf("wr%0d_addr", i), 32'(wq[i].a), 32'(a));
            chk($sformatf("wr%0d_data", i), wq[i].d, d);
            chk($sformatf("wr%0d_mask", i), 32'(wq[i].m), 32'(m));
        end else begin
            chk($sformatf("wr%0d_present", i), wq.size(), i + 1);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ctl"}, {ifc.busy, ifc.done, ifc.s_rdy, ifc.m_vld, ifc.mem_sel, ifc.mem_wr_en, ifc.mem_wr_mask}, 32'h0);
        chk({tag, "_addr"}, 32'(ifc.mem_addr), 32'h0);
        chk({tag, "_bus"}, ifc.mem_wdat | 32'(ifc.m_dat), 32'h0);
    endtask

    initial begin
        bq_t got;
        int  d0, s0, r0;

        ifc.start = 1'b0; ifc.mode = 1'b0; ifc.base_addr = '0; ifc.byte_count = '0;
        ifc.s_vld = 1'b0; ifc.s_dat = '0; ifc.m_rdy = 1'b0;
        reset_i = 1'b1;
        repeat (3) step();
        chk_idle_outputs("reset");
        reset_i = 1'b0;
        step();

        // 1: aligned 8-byte LOAD
        wq = {}; d0 = done_pulses;
        start_xfer(1'b0, 15'h0010, 18'd8);
        feed('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 0);
        wait_done();
        chk("t1_nwr", wq.size(), 2);
        chk_wr(0, 15'h0010, 32'h0403_0201, 4'hF);
        chk_wr(1, 15'h0011, 32'h0807_0605, 4'hF);
        chk("t1_done", done_pulses - d0, 1);

        // 2: partial last word across the address wrap
        wq = {};
        start_xfer(1'b0, 15'h7FFF, 18'd6);
        feed('{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF}, 0);
        wait_done();
        chk("t2_nwr", wq.size(), 2);
        chk_wr(0, 15'h7FFF, 32'hDDCC_BBAA, 4'hF);
        chk_wr(1, 15'h0000, 32'h0000_FFEE, 4'h3);

        // 3: 5-byte DUMP with a toggling consumer
        ram[15'h0020] = 32'h4433_2211;
        ram[15'h0021] = 32'h8877_6655;
        r0 = rd_cycles;
        start_xfer(1'b1, 15'h0020, 18'd5);
        drain(got);
        chk("t3_nbytes", got.size(), 5);
        foreach (got[i]) chk($sformatf("t3_byte%0d", i), 32'(got[i]), 32'(8'h11 * (i + 1)));
        chk("t3_reads", rd_cycles - r0, 2);

        // 4: zero-length transfers in both modes
        for (int md = 0; md < 2; md++) begin
            s0 = sel_cycles;
            start_xfer(md[0], 15'h0100, 18'd0);
            chk($sformatf("t4_m%0d_busy_done", md), {ifc.busy, ifc.done}, 2'b11);
            step();
            chk($sformatf("t4_m%0d_idle", md), {ifc.busy, ifc.done}, 2'b00);
            chk($sformatf("t4_m%0d_nosel", md), sel_cycles - s0, 0);
        end

        // 5: reset in the middle of a LOAD, then a clean 4-byte LOAD
        wq = {}; d0 = done_pulses;
        start_xfer(1'b0, 15'h0040, 18'd8);
        feed('{8'h5A, 8'hA5}, 0);
        reset_i = 1'b1;
        step();
        chk_idle_outputs("t5_rst");
        reset_i = 1'b0;
        repeat (3) step();
        chk("t5_nowr", wq.size(), 0);
        chk("t5_nodone", done_pulses - d0, 0);
        start_xfer(1'b0, 15'h0050, 18'd4);
        feed('{8'h10, 8'h20, 8'h30, 8'h40}, 0);
        wait_done();
        chk("t5_nwr", wq.size(), 1);
        chk_wr(0, 15'h0050, 32'h4030_2010, 4'hF);

        // 6: start pulsed while busy, input gaps of 0-3 cycles
        wq = {}; d0 = done_pulses; r0 = rd_cycles;
        start_xfer(1'b0, 15'h0060, 18'd7);
        step();
        start_xfer(1'b1, 15'h1234, 18'd3);
        feed('{8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77}, 1);
        wait_done();
        chk("t6_nwr", wq.size(), 2);
        chk_wr(0, 15'h0060, 32'h7473_7271, 4'hF);
        chk_wr(1, 15'h0061, 32'h0077_7675, 4'h7);
        chk("t6_noread", rd_cycles - r0, 0);
        chk("t6_done", done_pulses - d0, 1);

        chk("protocol", proto_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
